// File: rtl/key_sw_mmio.sv
// rtl/key_sw_mmio.sv - debounced KEY/SW memory-mapped responder with sticky status and interrupt

module key_sw_mmio_chan #(
    parameter int W               = 4,
    parameter bit INVERT          = 1'b0,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] raw,
    input  logic         data_rd,
    input  logic         ctrl_wr,
    input  logic         wr_ie,
    input  logic         wr_ovr,
    output logic [W-1:0] deb,
    output logic         rdy,
    output logic         ovr,
    output logic         ie
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [W-1:0] SYNC_RST = {W{INVERT}};

    logic [W-1:0]  sync_a;
    logic [W-1:0]  sync_b;
    logic [W-1:0]  s;
    logic [W-1:0]  s_q;
    logic [CW-1:0] cnt;
    logic          stable;
    logic          at_limit;
    logic          change;
    logic          ovr_set;

    // Inverting after the flops makes the reset value (all released) read as 0.
    assign s        = sync_a ^ SYNC_RST;
    assign s_q      = sync_b ^ SYNC_RST;
    assign stable   = (s == s_q) && (s != deb);
    assign at_limit = (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign change   = stable && at_limit;
    assign ovr_set  = change && rdy && !data_rd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a <= SYNC_RST;
            sync_b <= SYNC_RST;
            cnt    <= '0;
            deb    <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            if (!stable) begin
                cnt <= '0;
            end else if (at_limit) begin
                deb <= s_q;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // A change event outranks a same-cycle DATA read, which in turn suppresses overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy <= 1'b0;
            ovr <= 1'b0;
            ie  <= 1'b0;
        end else begin
            if (change) begin
                rdy <= 1'b1;
            end else if (data_rd) begin
                rdy <= 1'b0;
            end
            if (ovr_set) begin
                ovr <= 1'b1;
            end else if (ctrl_wr && !wr_ovr) begin
                ovr <= 1'b0;
            end
            if (ctrl_wr) begin
                ie <= wr_ie;
            end
        end
    end
endmodule

module key_sw_mmio #(
    parameter int               DBITS           = 32,
    parameter int               KEYBITS         = 4,
    parameter int               SWBITS          = 10,
    parameter logic [DBITS-1:0] ADDRKDATA       = 32'hFFFFF080,
    parameter logic [DBITS-1:0] ADDRKCTRL       = 32'hFFFFF084,
    parameter logic [DBITS-1:0] ADDRSDATA       = 32'hFFFFF090,
    parameter logic [DBITS-1:0] ADDRSCTRL       = 32'hFFFFF094,
    parameter int               DEBOUNCE_CYCLES = 500000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DBITS-1:0]   addr_i,
    input  logic [DBITS-1:0]   wdata_i,
    input  logic               we_i,
    input  logic               re_i,
    output logic [DBITS-1:0]   rdata_o,
    output logic               sel_o,
    input  logic [KEYBITS-1:0] KEY,
    input  logic [SWBITS-1:0]  SW,
    output logic               intr_o
);
    logic               hit_kdata;
    logic               hit_kctrl;
    logic               hit_sdata;
    logic               hit_sctrl;
    logic [KEYBITS-1:0] kdeb;
    logic [SWBITS-1:0]  sdeb;
    logic               krdy;
    logic               kovr;
    logic               kie;
    logic               srdy;
    logic               sovr;
    logic               sie;
    logic               unused_wdata;

    assign hit_kdata = (addr_i == ADDRKDATA);
    assign hit_kctrl = (addr_i == ADDRKCTRL);
    assign hit_sdata = (addr_i == ADDRSDATA);
    assign hit_sctrl = (addr_i == ADDRSCTRL);
    assign sel_o     = hit_kdata | hit_kctrl | hit_sdata | hit_sctrl;
    assign unused_wdata = ^{wdata_i[DBITS-1:5], wdata_i[3], wdata_i[1:0]};

    key_sw_mmio_chan #(
        .W               (KEYBITS),
        .INVERT          (1'b1),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key (
        .clk     (clk),
        .reset   (reset),
        .raw     (KEY),
        .data_rd (re_i && hit_kdata),
        .ctrl_wr (we_i && hit_kctrl),
        .wr_ie   (wdata_i[4]),
        .wr_ovr  (wdata_i[2]),
        .deb     (kdeb),
        .rdy     (krdy),
        .ovr     (kovr),
        .ie      (kie)
    );

    key_sw_mmio_chan #(
        .W               (SWBITS),
        .INVERT          (1'b0),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw (
        .clk     (clk),
        .reset   (reset),
        .raw     (SW),
        .data_rd (re_i && hit_sdata),
        .ctrl_wr (we_i && hit_sctrl),
        .wr_ie   (wdata_i[4]),
        .wr_ovr  (wdata_i[2]),
        .deb     (sdeb),
        .rdy     (srdy),
        .ovr     (sovr),
        .ie      (sie)
    );

    always_comb begin
        rdata_o = '0;
        if (hit_kdata) begin
            rdata_o[KEYBITS-1:0] = kdeb;
        end else if (hit_kctrl) begin
            rdata_o[4] = kie;
            rdata_o[2] = kovr;
            rdata_o[0] = krdy;
        end else if (hit_sdata) begin
            rdata_o[SWBITS-1:0] = sdeb;
        end else if (hit_sctrl) begin
            rdata_o[4] = sie;
            rdata_o[2] = sovr;
            rdata_o[0] = srdy;
        end
    end

    assign intr_o = (krdy & kie) | (srdy & sie);
endmodule

// File: tb/tb_key_sw_mmio.sv
// tb/tb_key_sw_mmio.sv - scoreboard bench for key_sw_mmio with a short debounce window

module tb_key_sw_mmio;
    localparam logic [31:0] KDATA = 32'hFFFFF080;
    localparam logic [31:0] KCTRL = 32'hFFFFF084;
    localparam logic [31:0] SDATA = 32'hFFFFF090;
    localparam logic [31:0] SCTRL = 32'hFFFFF094;

    logic        clk;
    logic        reset;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        we_i;
    logic        re_i;
    logic [31:0] rdata_o;
    logic        sel_o;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic        intr_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    key_sw_mmio #(.DEBOUNCE_CYCLES(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .we_i    (we_i),
        .re_i    (re_i),
        .rdata_o (rdata_o),
        .sel_o   (sel_o),
        .KEY     (KEY),
        .SW      (SW),
        .intr_o  (intr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic pop_cmp(input logic [31:0] act);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            check(tag_q.pop_front(), act, exp_q.pop_front());
        end
    endtask

    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr_i = a;
        re_i   = 1'b0;
        we_i   = 1'b0;
        push_exp(tag, exp);
        #1;
        pop_cmp(rdata_o);
    endtask

    task automatic flag(input string tag, input logic act, input logic exp);
        push_exp(tag, {31'd0, exp});
        pop_cmp({31'd0, act});
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        addr_i = a;
        re_i   = 1'b1;
        push_exp(tag, exp);
        #1;
        pop_cmp(rdata_o);
        @(posedge clk);
        #1;
        re_i = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr_i  = a;
        wdata_i = d;
        we_i    = 1'b1;
        @(posedge clk);
        #1;
        we_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset   = 1'b1;
        KEY     = 4'hF;
        SW      = 10'h000;
        addr_i  = 32'h0;
        wdata_i = 32'h0;
        we_i    = 1'b0;
        re_i    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state and address decode
        peek("rst_kctrl", KCTRL, 32'h0);
        peek("rst_sctrl", SCTRL, 32'h0);
        peek("rst_kdata", KDATA, 32'h0);
        flag("rst_sel_valid", sel_o, 1'b1);
        flag("rst_intr", intr_o, 1'b0);
        peek("bad_addr_rdata", 32'hFFFFF000, 32'h0);
        flag("bad_addr_sel", sel_o, 1'b0);

        // Key press latency: deb updates at edge N+5
        @(negedge clk);
        KEY = 4'b1110;
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        peek("key_lat_early", KDATA, 32'h0);
        @(posedge clk);
        @(negedge clk);
        peek("key_lat_on", KDATA, 32'h1);
        peek("key_rdy_set", KCTRL, 32'h1);
        rd("key_read", KDATA, 32'h1);
        peek("key_rdy_clr", KCTRL, 32'h0);

        // Short switch glitch is rejected
        @(negedge clk);
        SW = 10'h155;
        repeat (3) @(negedge clk);
        SW = 10'h000;
        repeat (10) @(posedge clk);
        @(negedge clk);
        peek("glitch_sdata", SDATA, 32'h0);
        peek("glitch_sctrl", SCTRL, 32'h0);

        // Overrun, CTRL write clears OVR, DATA read clears RDY
        @(negedge clk);
        SW = 10'h0AA;
        repeat (10) @(posedge clk);
        @(negedge clk);
        SW = 10'h3FF;
        repeat (10) @(posedge clk);
        @(negedge clk);
        peek("ovr_sctrl", SCTRL, 32'h5);
        peek("ovr_sdata", SDATA, 32'h3FF);
        wr(SCTRL, 32'h0);
        peek("ovr_cleared", SCTRL, 32'h1);
        rd("sw_read", SDATA, 32'h3FF);
        peek("sw_rdy_clr", SCTRL, 32'h0);

        // Interrupt follows KRDY & KIE
        wr(KCTRL, 32'h10);
        peek("kie_set", KCTRL, 32'h10);
        flag("intr_idle", intr_o, 1'b0);
        @(negedge clk);
        KEY = 4'b0110;
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        flag("intr_early", intr_o, 1'b0);
        @(posedge clk);
        @(negedge clk);
        flag("intr_on", intr_o, 1'b1);
        rd("key_read2", KDATA, 32'h9);
        flag("intr_off", intr_o, 1'b0);

        // DATA read coincident with a change event keeps RDY and blocks OVR
        @(negedge clk);
        KEY = 4'b0100;
        repeat (10) @(posedge clk);
        @(negedge clk);
        peek("pre_coinc_kctrl", KCTRL, 32'h11);
        peek("pre_coinc_kdata", KDATA, 32'hB);
        @(negedge clk);
        KEY = 4'b1111;
        @(posedge clk);
        repeat (4) @(posedge clk);
        rd("coinc_read", KDATA, 32'hB);
        peek("coinc_kctrl", KCTRL, 32'h11);
        peek("coinc_kdata", KDATA, 32'h0);
        flag("coinc_intr", intr_o, 1'b1);

        // Writes to DATA are ignored
        wr(SDATA, 32'h0);
        peek("data_wr_ignored", SDATA, 32'h3FF);

        // Reset mid-debounce, then nonzero SW debounces normally afterwards
        @(negedge clk);
        SW = 10'h001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        flag("async_rst_intr", intr_o, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        peek("mid_rst_kctrl", KCTRL, 32'h0);
        peek("mid_rst_sctrl", SCTRL, 32'h0);
        peek("mid_rst_sdata", SDATA, 32'h0);
        peek("mid_rst_kdata", KDATA, 32'h0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        peek("post_rst_sdata", SDATA, 32'h1);
        peek("post_rst_sctrl", SCTRL, 32'h1);
        flag("post_rst_intr_masked", intr_o, 1'b0);

        if (exp_q.size() != 0) check("scoreboard_drain", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
